// File: rtl/card_pkg.sv
// card_pkg: shared constants, state encoding and LFSR step for the card shoe
package card_pkg;

    localparam logic [5:0]  DECK_SIZE    = 6'd52;
    localparam logic [5:0]  LOW_WATER    = 6'd15;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting Fibonacci register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FILL    = 3'd1;
    localparam logic [2:0] SHUFFLE = 3'd2;
    localparam logic [2:0] READY   = 3'd3;
    localparam logic [2:0] DEAL    = 3'd4;

    localparam logic [1:0] DEST_PLAYER = 2'd0;
    localparam logic [1:0] DEST_SPLIT  = 2'd1;
    localparam logic [1:0] DEST_DEALER = 2'd2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// card_lfsr: 16-bit Fibonacci LFSR with synchronous load and step enable
module card_lfsr
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    // Load has priority over stepping so a fresh shuffle always starts from its seed
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= DEFAULT_SEED;
        else if (load)
            value <= seed;
        else if (step)
            value <= lfsr_next(value);
    end

endmodule

// File: rtl/card_shoe.sv
// card_shoe: 52-card deck fill, Fisher-Yates shuffle and one-card-per-request dealer
module card_shoe
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shuffle_start,
    input  logic [15:0] seed,
    input  logic        req,
    input  logic [1:0]  dest,
    output logic [3:0]  card,
    output logic        card_valid,
    output logic [1:0]  card_dest,
    output logic        ready,
    output logic [5:0]  cards_left,
    output logic        low_water,
    output logic        empty
);

    logic [2:0]  state;
    logic [5:0]  ptr;
    logic [5:0]  i;
    logic [5:0]  j;
    logic [3:0]  rank;
    logic [3:0]  tmp_i;
    logic [3:0]  tmp_j;
    logic        swap_wr;
    logic [1:0]  dest_r;
    logic [3:0]  deck [52];
    logic [15:0] lfsr_val;
    logic [5:0]  pick;
    logic        accept_shuffle;

    assign accept_shuffle = shuffle_start && (state == IDLE || state == READY);
    // Low six bits of the value the LFSR advances to in this cycle
    assign pick = {lfsr_val[4:0], ^(lfsr_val & LFSR_TAPS)};

    card_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept_shuffle),
        .seed  (seed == 16'd0 ? DEFAULT_SEED : seed),
        .step  (state == SHUFFLE),
        .value (lfsr_val)
    );

    // Control FSM: fill, shuffle (pick/write alternating), then serve requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 6'd0;
            i       <= 6'd0;
            j       <= 6'd0;
            rank    <= 4'd1;
            tmp_i   <= 4'd0;
            tmp_j   <= 4'd0;
            swap_wr <= 1'b0;
            dest_r  <= DEST_PLAYER;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (shuffle_start) begin
                        state <= FILL;
                        ptr   <= 6'd0;
                        rank  <= 4'd1;
                    end else if (state == READY && req && ptr != DECK_SIZE) begin
                        state  <= DEAL;
                        dest_r <= dest;
                    end
                end
                FILL: begin
                    ptr  <= ptr + 6'd1;
                    rank <= rank == 4'd13 ? 4'd1 : rank + 4'd1;
                    if (ptr == DECK_SIZE - 6'd1) begin
                        state   <= SHUFFLE;
                        i       <= DECK_SIZE - 6'd1;
                        swap_wr <= 1'b0;
                    end
                end
                SHUFFLE: begin
                    if (swap_wr) begin
                        swap_wr <= 1'b0;
                        if (i == 6'd1) begin
                            state <= READY;
                            ptr   <= 6'd0;
                        end else begin
                            i <= i - 6'd1;
                        end
                    end else if (pick <= i) begin
                        j       <= pick;
                        tmp_i   <= deck[i];
                        tmp_j   <= deck[pick];
                        swap_wr <= 1'b1;
                    end
                end
                DEAL: begin
                    ptr   <= ptr + 6'd1;
                    state <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Deck storage is not reset; every entry is rewritten by FILL before use
    always_ff @(posedge clk) begin
        if (state == FILL)
            deck[ptr] <= rank > 4'd10 ? 4'd10 : rank;
        else if (state == SHUFFLE && swap_wr) begin
            deck[i] <= tmp_j;
            deck[j] <= tmp_i;
        end
    end

    assign ready      = state == READY;
    assign card_valid = state == DEAL;
    assign empty      = ready && ptr == DECK_SIZE;
    assign card       = card_valid ? deck[ptr] : 4'd0;
    assign card_dest  = card_valid ? dest_r : 2'd0;
    assign cards_left = (ready || card_valid) ? DECK_SIZE - ptr : 6'd0;
    assign low_water  = cards_left < LOW_WATER;

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: randomized scoreboard bench for card_shoe against a shuffle model
module tb_card_shoe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        shuffle_start = 1'b0;
    logic [15:0] seed = 16'd0;
    logic        req = 1'b0;
    logic [1:0]  dest = 2'd0;
    logic [3:0]  card;
    logic        card_valid;
    logic [1:0]  card_dest;
    logic        ready;
    logic [5:0]  cards_left;
    logic        low_water;
    logic        empty;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [5:0] q[$];
    logic [3:0] mdeck [52];
    int mptr = 0;
    int hist [16];
    logic recording = 1'b0;
    logic [3:0] rec[$];
    logic burst = 1'b0;
    logic have_last = 1'b0;
    int last_cyc = 0;
    logic [5:0] e;

    card_shoe dut (
        .clk           (clk),
        .reset         (reset),
        .shuffle_start (shuffle_start),
        .seed          (seed),
        .req           (req),
        .dest          (dest),
        .card          (card),
        .card_valid    (card_valid),
        .card_dest     (card_dest),
        .ready         (ready),
        .cards_left    (cards_left),
        .low_water     (low_water),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] nx(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference: ordered fill then swap-based shuffle driven by the LFSR stream
    task automatic model_shuffle(input logic [15:0] s, output int n);
        logic [15:0] lf;
        logic [3:0] t;
        int ii, jj;
        lf = (s == 16'd0) ? 16'hACE1 : s;
        for (int k = 0; k < 52; k++) mdeck[k] = (k % 13 + 1 > 10) ? 4'd10 : 4'((k % 13) + 1);
        ii = 51;
        n = 0;
        while (ii >= 1) begin
            lf = nx(lf);
            n++;
            jj = int'(lf[5:0]);
            if (jj <= ii) begin
                t = mdeck[ii];
                mdeck[ii] = mdeck[jj];
                mdeck[jj] = t;
                lf = nx(lf);
                n++;
                ii--;
            end
        end
        mptr = 0;
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expected card
    always @(negedge clk) begin
        if (!reset && card_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("card", card, e[5:2]);
                chk("card_dest", card_dest, e[1:0]);
            end
            hist[card]++;
            if (recording) rec.push_back(card);
            if (burst && have_last) chk("valid_spacing", cyc - last_cyc, 2);
            last_cyc = cyc;
            have_last = 1'b1;
        end
    end

    task automatic do_shuffle(input logic [15:0] s, input logic r, input logic [1:0] d);
        int n, cnt;
        model_shuffle(s, n);
        @(negedge clk);
        shuffle_start = 1'b1;
        seed = s;
        if (r) begin
            req = 1'b1;
            dest = d;
        end
        @(posedge clk);
        #1;
        chk("lfsr_load", dut.u_lfsr.value, (s == 16'd0) ? 16'hACE1 : s);
        chk("ready_low_in_fill", ready, 0);
        @(negedge clk);
        shuffle_start = 1'b0;
        cnt = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ready || cnt > 20000) break;
        end
        chk("shuffle_cycles", cnt, 52 + n);
        chk("cards_left_full", cards_left, 52);
        chk("low_water_full", low_water, 0);
    endtask

    task automatic deal_one(input logic [1:0] d);
        int cnt;
        @(negedge clk);
        req = 1'b1;
        dest = d;
        q.push_back({mdeck[mptr], d});
        mptr++;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!card_valid && cnt < 20);
        if (!card_valid) chk("deal_timeout", 0, 1);
        req = 1'b0;
    endtask

    task automatic deal_burst(input int n, input logic [1:0] d);
        int got, cnt;
        @(negedge clk);
        for (int k = 0; k < n; k++) q.push_back({mdeck[mptr + k], d});
        mptr += n;
        have_last = 1'b0;
        burst = 1'b1;
        req = 1'b1;
        dest = d;
        got = 0;
        cnt = 0;
        while (got < n && cnt < 4 * n + 10) begin
            @(negedge clk);
            cnt++;
            if (card_valid) got++;
        end
        chk("burst_count", got, n);
        req = 1'b0;
        @(posedge clk);
        burst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!card_valid && cnt < 10);
        chk(nm, card_valid, 1);
        req = 1'b0;
    endtask

    function automatic int count_diffs(input logic [3:0] a[$], input logic [3:0] b[$]);
        int d;
        d = (a.size() == b.size()) ? 0 : 1000;
        for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) d++;
        return d;
    endfunction

    task automatic deal_all_recorded(output logic [3:0] out[$]);
        rec.delete();
        recording = 1'b1;
        for (int k = 0; k < 52; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            deal_one(2'($urandom_range(0, 3)));
        end
        @(posedge clk);
        recording = 1'b0;
        out = rec;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq_a[$], seq_b[$], seq_c[$];
        logic [15:0] rs;
        int cnt;
        for (int k = 0; k < 16; k++) hist[k] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_card", card, 0);
        chk("rst_valid", card_valid, 0);
        chk("rst_dest", card_dest, 0);
        chk("rst_ready", ready, 0);
        chk("rst_cards_left", cards_left, 0);
        chk("rst_low_water", low_water, 1);
        chk("rst_empty", empty, 0);
        chk("rst_lfsr", dut.u_lfsr.value, 16'hACE1);
        @(negedge clk);
        reset = 1'b0;

        do_shuffle(16'h0000, 1'b0, 2'd0);
        for (int k = 0; k < 16; k++) hist[k] = 0;
        deal_burst(52, 2'($urandom_range(0, 3)));
        for (int v = 1; v <= 9; v++) chk($sformatf("hist_%0d", v), hist[v], 4);
        chk("hist_10", hist[10], 16);
        @(negedge clk);
        req = 1'b1;
        repeat (10) @(negedge clk);
        chk("empty_after_52", empty, 1);
        chk("cards_left_zero", cards_left, 0);
        chk("low_water_zero", low_water, 1);
        req = 1'b0;

        do_shuffle(16'h1234, 1'b0, 2'd0);
        deal_all_recorded(seq_a);
        do_shuffle(16'h1234, 1'b0, 2'd0);
        deal_all_recorded(seq_b);
        do_shuffle(16'h1235, 1'b0, 2'd0);
        deal_all_recorded(seq_c);
        chk("same_seed_same_seq", count_diffs(seq_a, seq_b), 0);
        chk("diff_seed_diff_seq", count_diffs(seq_a, seq_c) > 0, 1);

        rs = 16'($urandom);
        do_shuffle(rs, 1'b0, 2'd0);
        deal_burst(38, 2'($urandom_range(0, 3)));
        #1;
        chk("cards_left_14", cards_left, 14);
        chk("low_water_14", low_water, 1);
        deal_burst(14, 2'd3);
        @(negedge clk);
        req = 1'b1;
        dest = 2'd1;
        repeat (8) @(negedge clk);
        chk("empty_pending", empty, 1);
        rs = 16'($urandom);
        do_shuffle(rs, 1'b1, 2'd1);
        q.push_back({mdeck[0], 2'd1});
        mptr = 1;
        wait_valid("pending_served");
        @(posedge clk);
        #1;
        chk("cards_left_51", cards_left, 51);

        deal_one(2'd0);
        deal_one(2'd3);
        rs = 16'($urandom);
        do_shuffle(rs, 1'b1, card_pkg::DEST_DEALER);
        q.push_back({mdeck[0], card_pkg::DEST_DEALER});
        mptr = 1;
        wait_valid("shuffle_wins_served");

        for (int r = 0; r < 2; r++) begin
            rs = 16'($urandom);
            do_shuffle(rs, 1'b0, 2'd0);
            deal_all_recorded(seq_a);
        end

        @(negedge clk);
        shuffle_start = 1'b1;
        seed = 16'($urandom);
        @(negedge clk);
        shuffle_start = 1'b0;
        cnt = 0;
        while (!(dut.state == card_pkg::SHUFFLE && dut.i == 6'd30) && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("reach_i30", dut.i, 30);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_card", card, 0);
        chk("mid_rst_valid", card_valid, 0);
        chk("mid_rst_dest", card_dest, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_cards_left", cards_left, 0);
        chk("mid_rst_low_water", low_water, 1);
        chk("mid_rst_empty", empty, 0);
        chk("mid_rst_lfsr", dut.u_lfsr.value, 16'hACE1);
        chk("mid_rst_ptr", dut.ptr, 0);
        chk("mid_rst_i", dut.i, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = 1'b1;
        dest = 2'($urandom_range(0, 3));
        repeat (100) @(negedge clk);
        chk("idle_ready", ready, 0);
        chk("idle_cards_left", cards_left, 0);
        req = 1'b0;

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 The block SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-002 The block SHALL have the following ports, in this order:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- shuffle_start  in  1  single-cycle pulse; fill and shuffle the deck.
- seed  in  16  LFSR seed, sampled on an accepted shuffle_start.
- req  in  1  card request level; the game FSM holds it until card_valid.
- dest  in  2  requester tag: 0 player, 1 split hand, 2 dealer, 3 reserved; sampled with req.
- card  out  4  dealt value 1..10 (Ace=1, J/Q/K=10).
- card_valid  out  1  one-cycle acknowledge; card and card_dest are valid in this cycle only.
- card_dest  out  2  echo of the dest sampled with the request.
- ready  out  1  deck shuffled, block in READY.
- cards_left  out  6  undealt cards, 0..52.
- low_water  out  1  cards_left < 15; game FSM reshuffles between rounds.
- empty  out  1  ready=1 and cards_left=0.

Function
REQ-003 The block SHALL hold a 52-entry x 4-bit deck array and a 6-bit deal pointer ptr; cards_left SHALL equal 52-ptr in READY/DEAL and 0 otherwise.
REQ-004 The state machine SHALL have the states IDLE, FILL, SHUFFLE, READY and DEAL; the reset state SHALL be IDLE.
REQ-005 IDLE or READY with shuffle_start=1: go to FILL and load the LFSR with seed, or with 16'hACE1 if seed=0. shuffle_start SHALL be ignored in FILL, SHUFFLE and DEAL.
REQ-006 FILL SHALL take 52 cycles, writing entry k = min((k mod 13)+1, 10) for k=0..51, then go to SHUFFLE with i=51.
REQ-007 SHUFFLE SHALL perform Fisher-Yates with rejection sampling:
- Each cycle: advance the LFSR and set j = lfsr[5:0].
- If j<=i: swap deck[i] and deck[j] over 2 cycles (read, write), then decrement i.
- If j>i: retry on the next cycle.
- After i=1 completes: set ptr=0 and go to READY.
REQ-008 The LFSR SHALL be a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, shifting once per SHUFFLE cycle only. The shuffle result SHALL be a deterministic function of the seed.
REQ-009 READY with req=1 and ptr<52: capture dest, go to DEAL.
REQ-010 DEAL SHALL last exactly one cycle:
- card_valid=1, card=deck[ptr], card_dest=captured dest.
- ptr increments.
- Return to READY.
Latency is one cycle from request sample to acknowledge.
REQ-011 req still high in the cycle after card_valid SHALL be treated as a new request; maximum rate is one card per 2 cycles.
REQ-012 READY with ptr=52 and req=1: no acknowledge; empty=1; req stays pending until a shuffle completes.
REQ-013 READY with shuffle_start=1 and req=1 in the same cycle: the shuffle SHALL win. The request is not acknowledged and is served after the new shuffle completes.
REQ-014 dest=3 SHALL be served normally and echoed unchanged.
REQ-015 ready and empty SHALL be combinational decodes of state and ptr. low_water SHALL be 1 whenever cards_left<15, including 0 in IDLE/FILL/SHUFFLE.

Reset
REQ-016 Reset SHALL force the following, from any state including mid-FILL or mid-SHUFFLE:
- state=IDLE, ptr=0, i=0, LFSR=16'hACE1.
- card=0, card_valid=0, card_dest=0.
- ready=0, cards_left=0, low_water=1, empty=0.
Deck contents are not reset and are don't-care until the next FILL.

Structure
REQ-017 A shared package card_pkg SHALL hold:
- DECK_SIZE=52, LOW_WATER=15, DEFAULT_SEED=16'hACE1.
- The LFSR tap mask.
- The state encoding.
- The dest encodings (DEST_PLAYER, DEST_SPLIT, DEST_DEALER).
REQ-018 The LFSR SHALL be a sub-module card_lfsr with ports clk, reset, load, seed, step and value[15:0].

Verification
REQ-019 Reset, then shuffle_start with seed=0x0000 -> LFSR loads 0xACE1; FILL lasts 52 cycles; ready rises after SHUFFLE.
REQ-020 After a shuffle, deal 52 cards by repeated req -> exactly four each of 1..9 and sixteen 10s; card_valid pulses are exactly 2 cycles apart under a constant req.
REQ-021 Two shuffles with seed=0x1234 -> identical 52-card sequences; seed=0x1235 -> a different sequence.
REQ-022 Deal 38 cards -> cards_left=14, low_water=1. Deal 14 more, then req=1 -> no card_valid, empty=1. shuffle_start -> pending req served after ready rises, with cards_left going 52->51.
REQ-023 In READY, assert req (dest=2) and shuffle_start in the same cycle -> no card_valid until the shuffle completes; first card_valid then has card_dest=2.
REQ-024 Assert reset during SHUFFLE (i=30) -> all outputs take their REQ-016 values immediately; a req with no shuffle_start is never acknowledged.
